// File: rtl/spi_flash_fetch.sv
// -----------------------------------------------------------------------------
// spi_flash_fetch
// Two-entry instruction buffer in front of a word-oriented SPI flash reader.
// Demand misses are fetched from the reader, optionally followed by a
// prefetch of the next sequential word. Every SPI read is followed by a
// fixed holdoff period before the reader may be started again.
//
// Ports
//   i_clk            single clock, all logic on its rising edge
//   i_rst_n          asynchronous active-low reset
//   i_bus_start      one-cycle request pulse
//   i_bus_addr       24-bit word address, valid with i_bus_start
//   i_flush          invalidate both buffer entries
//   o_bus_q          returned instruction word (held until next o_bus_done)
//   o_bus_done       one-cycle completion pulse
//   o_bus_busy       request pending or demand fetch in service
//   o_spi_address    word address to the flash reader
//   o_spi_start      read request to the flash reader
//   i_spi_instr      word from the flash reader
//   i_spi_init_done  flash reader initialised
//   i_spi_recv_done  flash reader word valid (one-cycle pulse)
// -----------------------------------------------------------------------------
module spi_flash_fetch #(
  parameter int PREFETCH = 1,
  parameter int HOLDOFF  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bus_start,
  input  logic [23:0] i_bus_addr,
  input  logic        i_flush,
  output logic [31:0] o_bus_q,
  output logic        o_bus_done,
  output logic        o_bus_busy,
  output logic [23:0] o_spi_address,
  output logic        o_spi_start,
  input  logic [31:0] i_spi_instr,
  input  logic        i_spi_init_done,
  input  logic        i_spi_recv_done
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_PREF  = 3'd4
  } state_t;

  // The counter is loaded with HOLDOFF-1 on the fill edge, so HOLD lasts
  // exactly HOLDOFF cycles before spi_start can rise again.
  localparam logic [7:0] HOLD_LOAD = (HOLDOFF > 1) ? 8'(HOLDOFF - 1) : 8'd0;

  // Tag match for one buffer entry.
  function automatic logic f_hit(input logic valid, input logic [23:0] tag,
                                 input logic [23:0] addr);
    return valid && (tag == addr);
  endfunction

  state_t      r_state, w_state_nx;
  logic        r_pend, w_pend_nx;
  logic [23:0] r_pend_addr, w_pend_addr_nx;
  logic [23:0] r_dem_addr, w_dem_addr_nx;
  logic [7:0]  r_hold_cnt, w_hold_nx;
  logic        r_after_pref, w_after_pref_nx;
  logic        r_mru, w_mru_nx;
  logic [31:0] r_bus_q, w_bus_q_nx;
  logic        r_bus_done, w_bus_done_nx;
  logic        r_bus_busy;
  logic        r_spi_start, w_spi_start_nx;
  logic [23:0] r_spi_addr, w_spi_addr_nx;
  logic [1:0]  r_valid;
  logic [23:0] r_tag [2];
  logic [31:0] r_data [2];
  logic        w_fill;

  logic        w_victim;
  logic        w_req_vld;
  logic [23:0] w_req_addr;
  logic        w_req_hit0, w_req_hit1, w_req_hit;
  logic [23:0] w_nxt_addr;
  logic        w_nxt_hit;

  // In IDLE a request arriving this cycle is serviced directly, so the
  // lookup address bypasses the pending register when it is empty.
  assign w_victim   = ~r_mru;
  assign w_req_vld  = r_pend | i_bus_start;
  assign w_req_addr = r_pend ? r_pend_addr : i_bus_addr;
  assign w_req_hit0 = f_hit(r_valid[0], r_tag[0], w_req_addr);
  assign w_req_hit1 = f_hit(r_valid[1], r_tag[1], w_req_addr);
  assign w_req_hit  = w_req_hit0 | w_req_hit1;
  assign w_nxt_addr = r_dem_addr + 24'd1;
  assign w_nxt_hit  = f_hit(r_valid[0], r_tag[0], w_nxt_addr) |
                      f_hit(r_valid[1], r_tag[1], w_nxt_addr);

  assign o_bus_q       = r_bus_q;
  assign o_bus_done    = r_bus_done;
  assign o_bus_busy    = r_bus_busy;
  assign o_spi_address = r_spi_addr;
  assign o_spi_start   = r_spi_start;

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    w_state_nx      = r_state;
    w_pend_nx       = r_pend;
    w_pend_addr_nx  = r_pend_addr;
    w_dem_addr_nx   = r_dem_addr;
    w_hold_nx       = r_hold_cnt;
    w_after_pref_nx = r_after_pref;
    w_mru_nx        = r_mru;
    w_bus_q_nx      = r_bus_q;
    w_bus_done_nx   = 1'b0;
    w_spi_start_nx  = r_spi_start;
    w_spi_addr_nx   = r_spi_addr;
    w_fill          = 1'b0;

    // A new request is only accepted into an empty pending slot.
    if (i_bus_start && !r_pend) begin
      w_pend_nx      = 1'b1;
      w_pend_addr_nx = i_bus_addr;
    end else begin
      w_pend_nx      = r_pend;
    end

    case (r_state)
      ST_INIT: begin
        if (i_spi_init_done) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_INIT;
        end
      end
      ST_IDLE: begin
        // Holding off while bus_done is high keeps completions one cycle apart.
        if (w_req_vld && !r_bus_done) begin
          if (w_req_hit) begin
            w_bus_q_nx    = w_req_hit1 ? r_data[1] : r_data[0];
            w_bus_done_nx = 1'b1;
            w_pend_nx     = 1'b0;
            w_mru_nx      = w_req_hit1;
          end else begin
            w_pend_nx      = 1'b1;
            w_pend_addr_nx = w_req_addr;
            w_dem_addr_nx  = w_req_addr;
            w_spi_start_nx = 1'b1;
            w_spi_addr_nx  = w_req_addr;
            w_state_nx     = ST_FETCH;
          end
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (i_spi_recv_done) begin
          w_fill          = 1'b1;
          w_mru_nx        = w_victim;
          w_bus_q_nx      = i_spi_instr;
          w_bus_done_nx   = 1'b1;
          w_pend_nx       = 1'b0;
          w_spi_start_nx  = 1'b0;
          w_hold_nx       = HOLD_LOAD;
          w_after_pref_nx = 1'b0;
          w_state_nx      = ST_HOLD;
        end else begin
          w_state_nx = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt != 8'd0) begin
          w_hold_nx = r_hold_cnt - 8'd1;
        end else if (!r_after_pref && (PREFETCH == 1) && !w_nxt_hit) begin
          w_spi_start_nx = 1'b1;
          w_spi_addr_nx  = w_nxt_addr;
          w_state_nx     = ST_PREF;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_PREF: begin
        if (i_spi_recv_done) begin
          w_fill          = 1'b1;
          w_mru_nx        = w_victim;
          w_spi_start_nx  = 1'b0;
          w_hold_nx       = HOLD_LOAD;
          w_after_pref_nx = 1'b1;
          w_state_nx      = ST_HOLD;
        end else begin
          w_state_nx = ST_PREF;
        end
      end
      default: begin
        w_state_nx     = ST_INIT;
        w_spi_start_nx = 1'b0;
      end
    endcase
  end

  // State, control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_INIT;
      r_pend       <= 1'b0;
      r_pend_addr  <= 24'd0;
      r_dem_addr   <= 24'd0;
      r_hold_cnt   <= 8'd0;
      r_after_pref <= 1'b0;
      r_mru        <= 1'b0;
      r_bus_q      <= 32'd0;
      r_bus_done   <= 1'b0;
      r_bus_busy   <= 1'b0;
      r_spi_start  <= 1'b0;
      r_spi_addr   <= 24'd0;
    end else begin
      r_state      <= w_state_nx;
      r_pend       <= w_pend_nx;
      r_pend_addr  <= w_pend_addr_nx;
      r_dem_addr   <= w_dem_addr_nx;
      r_hold_cnt   <= w_hold_nx;
      r_after_pref <= w_after_pref_nx;
      r_mru        <= w_mru_nx;
      r_bus_q      <= w_bus_q_nx;
      r_bus_done   <= w_bus_done_nx;
      r_bus_busy   <= w_pend_nx | (w_state_nx == ST_FETCH);
      r_spi_start  <= w_spi_start_nx;
      r_spi_addr   <= w_spi_addr_nx;
    end
  end

  // Buffer storage; flush beats a coincident fill so the entry stays invalid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_tag[i]  <= 24'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      if (i_flush) begin
        r_valid <= 2'b00;
      end else if (w_fill) begin
        r_valid[w_victim] <= 1'b1;
      end else begin
        r_valid <= r_valid;
      end
      if (w_fill) begin
        r_tag[w_victim]  <= r_spi_addr;
        r_data[w_victim] <= i_spi_instr;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_fetch.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_fetch
// Self-checking bench: a flash reader model answers SPI reads, a scoreboard
// holds expected bus words and expected SPI read addresses, a table of
// request vectors exercises hits and misses, and hand-written sequences
// cover holdoff timing, prefetch wrap, flush and reset corner cases.
// -----------------------------------------------------------------------------
module tb_spi_flash_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_start;
  logic [23:0] bus_addr;
  logic        flush_main, flush_rd, flush;
  logic [31:0] bus_q;
  logic        bus_done, bus_busy;
  logic [23:0] spi_address;
  logic        spi_start;
  logic [31:0] spi_instr;
  logic        init_done, recv_done;

  assign flush = flush_main | flush_rd;

  always #5 clk = ~clk;

  spi_flash_fetch #(.PREFETCH(1), .HOLDOFF(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_bus_start(bus_start), .i_bus_addr(bus_addr),
    .i_flush(flush), .o_bus_q(bus_q), .o_bus_done(bus_done), .o_bus_busy(bus_busy),
    .o_spi_address(spi_address), .o_spi_start(spi_start), .i_spi_instr(spi_instr),
    .i_spi_init_done(init_done), .i_spi_recv_done(recv_done)
  );

  typedef struct {
    logic [23:0] addr;
    logic [31:0] data;
    int          n_rd;
    logic [23:0] rd0;
    logic [23:0] rd1;
    int          lat;
  } vec_t;

  vec_t        vecs [5];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  logic [23:0] rd_q  [$];
  logic        arm_flush = 1'b0;

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    if (a == 24'h000010) return 32'hDEADBEEF;
    else return {8'h5A, a} ^ 32'h0F0F_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Flash reader model: 3 idle cycles after spi_start, then a recv_done pulse.
  initial begin
    logic        busy;
    int          cnt;
    logic [23:0] a;
    busy = 1'b0; cnt = 0; a = 24'd0;
    recv_done = 1'b0; spi_instr = 32'd0; flush_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0; recv_done = 1'b0; flush_rd = 1'b0;
      end else if (recv_done) begin
        recv_done = 1'b0; flush_rd = 1'b0;
      end else if (busy) begin
        if (cnt == 0) begin
          recv_done = 1'b1;
          spi_instr = flash_word(a);
          flush_rd  = arm_flush;
          busy      = 1'b0;
        end else begin
          cnt--;
        end
      end else if (spi_start) begin
        busy = 1'b1; cnt = 2; a = spi_address;
        if (rd_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL spi_read: unexpected read of %h", spi_address);
        end else begin
          check("spi_address", {8'h00, spi_address}, {8'h00, rd_q.pop_front()});
        end
      end
    end
  end

  // Bus monitor: scoreboard pop on bus_done, no back-to-back done, bus_q held.
  initial begin
    logic        prev_done;
    logic [31:0] last_q;
    prev_done = 1'b0; last_q = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0; last_q = 32'd0;
      end else begin
        if (bus_done) begin
          check("done_back_to_back", {31'd0, prev_done}, 32'd0);
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL bus_done: unexpected completion, bus_q %h", bus_q);
          end else begin
            check("bus_q", bus_q, exp_q.pop_front());
          end
          last_q = bus_q;
        end else begin
          check("bus_q_hold", bus_q, last_q);
        end
        prev_done = bus_done;
      end
    end
  end

  task automatic pulse_req(input logic [23:0] a);
    bus_start = 1'b1; bus_addr = a;
    @(negedge clk);
    bus_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int got;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus_done) begin got = 1; break; end
      @(negedge clk);
    end
    check(name, got, 1);
  endtask

  task automatic run_req(input logic [23:0] a, input logic [31:0] d, input int n_rd,
                         input logic [23:0] r0, input logic [23:0] r1, input int lat);
    int n;
    int got;
    exp_q.push_back(d);
    if (n_rd > 0) rd_q.push_back(r0);
    if (n_rd > 1) rd_q.push_back(r1);
    bus_start = 1'b1; bus_addr = a;
    n = 0; got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      bus_start = 1'b0;
      n++;
      if (bus_done) begin got = 1; break; end
    end
    check("done_timeout", got, 1);
    if (lat != 0) check("latency", n, lat);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int n;
    vecs[0] = '{24'h000010, 32'hDEADBEEF,          0, 24'h0,      24'h0,      1};
    vecs[1] = '{24'h000011, flash_word(24'h11),     0, 24'h0,      24'h0,      1};
    vecs[2] = '{24'h000100, flash_word(24'h100),    2, 24'h000100, 24'h000101, 5};
    vecs[3] = '{24'h000101, flash_word(24'h101),    0, 24'h0,      24'h0,      1};
    vecs[4] = '{24'h000100, flash_word(24'h100),    0, 24'h0,      24'h0,      1};

    rst_n = 1'b0; bus_start = 1'b0; bus_addr = 24'd0; flush_main = 1'b0; init_done = 1'b0;
    #2;
    check("rst_bus_q", bus_q, 32'd0);
    check("rst_bus_done", {31'd0, bus_done}, 32'd0);
    check("rst_bus_busy", {31'd0, bus_busy}, 32'd0);
    check("rst_spi_start", {31'd0, spi_start}, 32'd0);
    check("rst_spi_address", {8'd0, spi_address}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Request before init_done is held pending, then served on reaching IDLE.
    exp_q.push_back(32'hDEADBEEF);
    rd_q.push_back(24'h000010);
    rd_q.push_back(24'h000011);
    pulse_req(24'h000010);
    check("init_busy", {31'd0, bus_busy}, 32'd1);
    repeat (3) @(negedge clk);
    check("init_no_start", {31'd0, spi_start}, 32'd0);
    init_done = 1'b1;
    wait_done("first_done");
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (spi_start) break;
    end
    check("holdoff_cycles", n, 4);
    repeat (30) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_req(vecs[i].addr, vecs[i].data, vecs[i].n_rd, vecs[i].rd0, vecs[i].rd1, vecs[i].lat);
    end

    // Wrap prefetch at the top of the address space; request it mid-prefetch.
    exp_q.push_back(flash_word(24'hFFFFFF));
    exp_q.push_back(flash_word(24'h000000));
    rd_q.push_back(24'hFFFFFF);
    rd_q.push_back(24'h000000);
    pulse_req(24'hFFFFFF);
    wait_done("wrap_demand");
    for (int k = 0; k < 20; k++) begin
      if (spi_start) break;
      @(negedge clk);
    end
    check("wrap_pref_addr", {8'd0, spi_address}, 32'h0000_0000);
    pulse_req(24'h000000);
    wait_done("wrap_pending");
    repeat (30) @(negedge clk);

    // Flush forces a re-read of a previously buffered word.
    flush_main = 1'b1;
    @(negedge clk);
    flush_main = 1'b0;
    run_req(24'h000010, 32'hDEADBEEF, 2, 24'h000010, 24'h000011, 5);

    // Flush coincident with a demand fill: word still returned, entry left invalid.
    exp_q.push_back(flash_word(24'h40));
    rd_q.push_back(24'h000040);
    rd_q.push_back(24'h000041);
    arm_flush = 1'b1;
    pulse_req(24'h000040);
    wait_done("flush_fill_done");
    arm_flush = 1'b0;
    repeat (30) @(negedge clk);
    run_req(24'h000040, flash_word(24'h40), 1, 24'h000040, 24'h0, 5);

    // Second request while busy is dropped; exactly one completion.
    exp_q.push_back(flash_word(24'h20));
    rd_q.push_back(24'h000020);
    rd_q.push_back(24'h000021);
    pulse_req(24'h000020);
    pulse_req(24'h000030);
    wait_done("drop_done");
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_done) n++;
    end
    check("drop_extra_done", n, 0);

    // Reset in the middle of a demand fetch.
    rd_q.push_back(24'h000050);
    pulse_req(24'h000050);
    for (int k = 0; k < 20; k++) begin
      if (spi_start) break;
      @(negedge clk);
    end
    check("rst_fetch_started", {31'd0, spi_start}, 32'd1);
    #2;
    rst_n = 1'b0; init_done = 1'b0;
    #1;
    check("rst_mid_spi_start", {31'd0, spi_start}, 32'd0);
    check("rst_mid_bus_done", {31'd0, bus_done}, 32'd0);
    check("rst_mid_bus_busy", {31'd0, bus_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    init_done = 1'b1;
    @(negedge clk);
    run_req(24'h000050, flash_word(24'h50), 2, 24'h000050, 24'h000051, 5);

    check("exp_q_empty", exp_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_fetch.md
SPI_FLASH_FETCH -- requirements
Module: spi_flash_fetch

Interface
REQ-001 Parameter PREFETCH, default 1, meaning: when 1, fetch the next sequential word into the spare entry after each demand miss.
REQ-002 Parameter HOLDOFF, default 4, meaning: idle cycles after spi_recv_done before spi_start may rise again.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 bus_start  input  1  one-cycle request pulse.
REQ-006 bus_addr  input  24  word address, valid in the bus_start cycle.
REQ-007 flush  input  1  invalidate both buffer entries.
REQ-008 bus_q  output  32  returned instruction word.
REQ-009 bus_done  output  1  one-cycle completion pulse.
REQ-010 bus_busy  output  1  high when a request is pending or in service.
REQ-011 spi_address  output  24  word address to the flash reader.
REQ-012 spi_start  output  1  read request to the flash reader.
REQ-013 spi_instr  input  32  word from the flash reader.
REQ-014 spi_init_done  input  1  flash reader initialised.
REQ-015 spi_recv_done  input  1  flash reader word valid, one-cycle pulse.

Function
REQ-016 Buffer SHALL hold two entries {valid, tag[23:0], data[31:0]}; hit = valid and tag == request address; entry 0 and entry 1 SHALL never both be valid with equal tags.
REQ-017 FSM states: INIT, IDLE, FETCH, HOLD, PREF; INIT -> IDLE when spi_init_done sampled 1.
REQ-018 bus_start SHALL be captured, with bus_addr, into a pending register in any state; bus_start while pending is already set SHALL be ignored.
REQ-019 bus_busy SHALL equal pending OR (state == FETCH for a demand).
REQ-020 IDLE with pending hit: bus_q = entry data and bus_done = 1 in the next cycle; pending cleared; no SPI activity.
REQ-021 IDLE with pending miss: next cycle spi_address = pending address, spi_start = 1, state FETCH.
REQ-022 IDLE SHALL service pending in the same cycle bus_start arrives (hit latency 1 cycle from bus_start).
REQ-023 FETCH: spi_start held 1 and spi_address held stable until spi_recv_done sampled 1; next cycle spi_start = 0.
REQ-024 On spi_recv_done in a demand FETCH: spi_instr written to the non-MRU entry (MRU = last hit or fill); bus_q = spi_instr, bus_done = 1 next cycle; pending cleared; state HOLD.
REQ-025 HOLD SHALL last exactly HOLDOFF cycles with spi_start = 0, then go to PREF if PREFETCH == 1 and (demand address + 1) misses, else IDLE.
REQ-026 Next address SHALL be 24-bit modulo: 24'hFFFFFF + 1 = 24'h000000.
REQ-027 PREF behaves as FETCH but fills the non-MRU entry without bus_done, then HOLD for HOLDOFF cycles, then IDLE (no chained prefetch).
REQ-028 Requests arriving during FETCH/PREF/HOLD SHALL wait in pending; an SPI read in flight is never aborted.
REQ-029 A pending request matching an in-flight prefetch address SHALL be answered from the buffer after that fill (no second SPI read).
REQ-030 flush clears both valid bits next cycle; flush coincident with a fill SHALL win (entry stays invalid) while a demand fill still returns bus_q/bus_done.
REQ-031 spi_recv_done outside FETCH/PREF SHALL be ignored.
REQ-032 bus_done SHALL never be high two consecutive cycles; bus_q holds its value until the next bus_done.

Reset
REQ-033 reset low SHALL immediately force: state INIT, spi_start 0, spi_address 0, bus_done 0, bus_busy 0, bus_q 0, pending 0, both valid bits 0, holdoff counter 0.
REQ-034 reset asserted mid-FETCH SHALL drop spi_start at once; no bus_done is issued for the aborted request.
REQ-035 After reset release, bus_start before spi_init_done SHALL be held pending and serviced on entering IDLE.

Verification
REQ-036 spi_init_done=1, bus_start addr 0x000010, reader model returns 0xDEADBEEF -> spi_address 0x000010, one bus_done with bus_q 0xDEADBEEF, then 4 idle cycles, then spi_start for 0x000011.
REQ-037 Repeat addr 0x000010 after prefetch done -> bus_done 1 cycle later, bus_q 0xDEADBEEF, spi_start stays 0; same for 0x000011 with prefetched data.
REQ-038 Miss at 0xFFFFFF -> prefetch address 0x000000; bus_start 0x000000 during that prefetch -> served after fill with no extra spi_start.
REQ-039 flush pulse, then bus_start 0x000010 -> new SPI read issued (miss).
REQ-040 reset low during FETCH -> spi_start 0 same cycle, no bus_done; after release and spi_init_done, new request completes normally.
REQ-041 bus_start pulses at 0x20 then 0x30 while busy -> 0x20 served, 0x30 dropped, exactly one bus_done.
